// File: rtl/uart_rx_deframer_if.sv
// Byte stream from the UART receiver in, payload stream to the command decoder out.
interface uart_rx_deframer_if;
  logic       rx_valid;
  logic       rx_break;
  logic [7:0] rx_data;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output rx_valid, rx_break, rx_data, m_ready,
    input  m_data, m_last, m_valid
  );

  modport slave (
    input  rx_valid, rx_break, rx_data, m_ready,
    output m_data, m_last, m_valid
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// Parses SOF/LEN/payload/CSUM frames from the UART receiver, buffers payload
// in a FIFO with a last marker, and pulses a per-frame status.
module uart_rx_deframer #(
  parameter int         FIFO_DEPTH     = 16,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 104166
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                uart_rx_en,
  uart_rx_deframer_if.slave   bus,
  output logic                pkt_done,
  output logic                pkt_ok,
  output logic [4:0]          pkt_err
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [16:0] TMO_LAST  = 17'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_remaining, r_csum;
  logic [16:0] r_tmo;
  logic        r_ovf;
  logic [8:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_pkt_done, r_pkt_ok;
  logic [4:0]  r_pkt_err;

  logic       w_byte_ev, w_brk_ev, w_tmo_hit;
  logic       w_push, w_load_len, w_done, w_ok;
  logic [3:0] w_err;
  logic       w_pop, w_empty, w_full, w_wr_en;

  assign uart_rx_en = enable & ~rst;
  assign w_byte_ev  = bus.rx_valid & ~bus.rx_break;
  assign w_brk_ev   = bus.rx_valid &  bus.rx_break;
  assign w_tmo_hit  = (r_tmo == TMO_LAST) && !bus.rx_valid;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.m_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);

  assign bus.m_valid = !w_empty;
  assign bus.m_data  = r_mem[r_rd_ptr[AW-1:0]][7:0];
  assign bus.m_last  = r_mem[r_rd_ptr[AW-1:0]][8];

  assign pkt_done = r_pkt_done;
  assign pkt_ok   = r_pkt_ok;
  assign pkt_err  = r_pkt_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HUNT;
    else     r_state <= w_state_nxt;
  end

  // w_err is {len, break, timeout, csum}; overflow is appended from r_ovf
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_load_len  = 1'b0;
    w_done      = 1'b0;
    w_ok        = 1'b0;
    w_err       = 4'd0;
    if (!enable) begin
      w_state_nxt = S_HUNT;
    end else if (r_state != S_HUNT && w_brk_ev) begin
      w_done      = 1'b1;
      w_err       = 4'b0100;
      w_state_nxt = S_HUNT;
    end else if (r_state != S_HUNT && w_tmo_hit) begin
      w_done      = 1'b1;
      w_err       = 4'b0010;
      w_state_nxt = S_HUNT;
    end else if (w_byte_ev) begin
      case (r_state)
        S_HUNT: begin
          if (bus.rx_data == SOF_BYTE) w_state_nxt = S_LEN;
        end
        S_LEN: begin
          if (bus.rx_data != 8'd0 && bus.rx_data <= MAX_LEN_B) begin
            w_load_len  = 1'b1;
            w_state_nxt = S_PAYLOAD;
          end else begin
            w_done      = 1'b1;
            w_err       = 4'b1000;
            w_state_nxt = S_HUNT;
          end
        end
        S_PAYLOAD: begin
          w_push = 1'b1;
          if (r_remaining == 8'd1) w_state_nxt = S_CSUM;
        end
        S_CSUM: begin
          w_done      = 1'b1;
          w_ok        = (bus.rx_data == r_csum) && !r_ovf;
          w_err       = {3'b000, bus.rx_data != r_csum};
          w_state_nxt = S_HUNT;
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= 8'd0;
      r_csum      <= 8'd0;
      r_tmo       <= 17'd0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_state_nxt == S_HUNT || bus.rx_valid) r_tmo <= 17'd0;
      else                                       r_tmo <= r_tmo + 17'd1;
      if (w_load_len) begin
        r_remaining <= bus.rx_data;
        r_csum      <= bus.rx_data;
      end else if (w_push) begin
        r_remaining <= r_remaining - 8'd1;
        r_csum      <= r_csum ^ bus.rx_data;
      end
      if (!enable || w_load_len || (r_state == S_HUNT && w_state_nxt == S_LEN))
        r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  // Payload FIFO: storage is not reset, only the pointers
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {r_remaining == 8'd1, bus.rx_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Status stage: registered, one cycle after the terminating byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_done <= 1'b0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 5'd0;
    end else begin
      r_pkt_done <= w_done;
      r_pkt_ok   <= w_ok;
      r_pkt_err  <= (w_done && !w_ok) ? {r_ovf, w_err} : 5'd0;
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized and directed frame stimulus against a frame-level reference model.
module tb_uart_rx_deframer;
  localparam int         DEPTH = 4;
  localparam int         TMO   = 64;
  localparam int         MAXL  = 64;
  localparam logic [7:0] SOF   = 8'hA5;

  logic clk = 1'b0;
  logic rst, enable, uart_rx_en, pkt_done, pkt_ok;
  logic [4:0] pkt_err;
  uart_rx_deframer_if bus();

  uart_rx_deframer #(.FIFO_DEPTH(DEPTH), .SOF_BYTE(SOF), .MAX_LEN(MAXL),
                     .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .uart_rx_en(uart_rx_en),
    .bus(bus), .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_err(pkt_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame bytes collected in a queue, checksum by XOR reduction
  logic [8:0] fq[$];
  logic [7:0] fr[$];
  bit         in_frame = 0, ovf = 0;
  int         idle = 0;
  logic       exp_done = 0, exp_ok = 0;
  logic [4:0] exp_err = 0;

  task automatic mdl_end(input bit ok, input logic [4:0] err);
    exp_done = 1'b1;
    exp_ok   = ok;
    exp_err  = ok ? 5'd0 : (err | {ovf, 4'b0000});
    in_frame = 0;
    idle     = 0;
  endtask

  task automatic model_step();
    logic [7:0] b, x;
    int n, lenv;
    exp_done = 0; exp_ok = 0; exp_err = 0;
    if (rst) begin
      fq.delete(); fr.delete(); in_frame = 0; ovf = 0; idle = 0;
      return;
    end
    if (fq.size() > 0 && bus.m_ready) void'(fq.pop_front());
    if (!enable) begin
      in_frame = 0; ovf = 0; idle = 0;
      return;
    end
    b = bus.rx_data;
    if (!in_frame) begin
      if (bus.rx_valid && !bus.rx_break && b == SOF) begin
        in_frame = 1; fr.delete(); ovf = 0; idle = 0;
      end
      return;
    end
    if (bus.rx_valid && bus.rx_break) begin mdl_end(0, 5'b00100); return; end
    if (!bus.rx_valid) begin
      if (idle == TMO - 1) mdl_end(0, 5'b00010);
      else idle++;
      return;
    end
    idle = 0;
    fr.push_back(b);
    n = fr.size();
    lenv = int'(fr[0]);
    if (n == 1) begin
      if (lenv == 0 || lenv > MAXL) mdl_end(0, 5'b01000);
      return;
    end
    if (n <= lenv + 1) begin
      if (fq.size() < DEPTH) fq.push_back({(n == lenv + 1), b});
      else ovf = 1;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < n - 1; i++) x ^= fr[i];
    if (x == b && !ovf) mdl_end(1, 5'd0);
    else mdl_end(0, {4'b0000, x != b});
  endtask

  always @(posedge clk) model_step();

  bit         mon_on = 0;
  int         cap_n = 0;
  logic       cap_ok;
  logic [4:0] cap_err;
  logic [8:0] got_q[$];

  always @(negedge clk) begin
    if (mon_on) begin
      check_eq("uart_rx_en", uart_rx_en, enable & ~rst);
      check_eq("pkt_done", pkt_done, exp_done);
      check_eq("pkt_ok", pkt_ok, exp_ok);
      check_eq("pkt_err", pkt_err, exp_err);
      check_eq("m_valid", bus.m_valid, fq.size() != 0);
      if (fq.size() != 0) check_eq("m_head", {bus.m_last, bus.m_data}, fq[0]);
      if (pkt_done === 1'b1) begin cap_n++; cap_ok = pkt_ok; cap_err = pkt_err; end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got_q.push_back({bus.m_last, bus.m_data});
    end
  end

  bit rdy_rand = 0;
  task automatic tick();
    @(posedge clk); #1;
    if (rdy_rand) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1; bus.rx_break = 1'b0; bus.rx_data = b;
    tick();
    bus.rx_valid = 1'b0; bus.rx_data = 8'($urandom);
  endtask

  task automatic put_break();
    bus.rx_valid = 1'b1; bus.rx_break = 1'b1; bus.rx_data = 8'($urandom);
    tick();
    bus.rx_valid = 1'b0; bus.rx_break = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) put_byte(s[i]);
    tick(); tick();
  endtask

  task automatic expect_status(input string tag, input int n0, input bit ok, input logic [4:0] err);
    check_eq({tag, "_cnt"}, cap_n - n0, 1);
    check_eq({tag, "_ok"}, cap_ok, ok);
    check_eq({tag, "_err"}, cap_err, err);
  endtask

  function automatic int rgap();
    int r = $urandom_range(0, 31);
    if (r < 22) return 0;
    if (r < 28) return r - 21;
    if (r == 28) return TMO - 2;
    if (r == 29) return TMO - 1;
    if (r == 30) return TMO;
    return TMO + 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [7:0] s[$];
    logic [7:0] x;
    rst = 1; enable = 1; bus.rx_valid = 0; bus.rx_break = 0; bus.rx_data = 0; bus.m_ready = 1;
    tick();
    mon_on = 1;
    tick(); rst = 0; tick();
    check_eq("reset_m_valid", bus.m_valid, 0);
    check_eq("reset_pkt_done", pkt_done, 0);

    // Good frame, then the same frame with a bad checksum
    n0 = cap_n; got_q.delete();
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    expect_status("good", n0, 1, 5'b00000);
    check_eq("good_nbytes", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check_eq("good_b0", got_q[0], 9'h011);
      check_eq("good_b1", got_q[1], 9'h022);
      check_eq("good_b2", got_q[2], 9'h133);
    end
    n0 = cap_n;
    send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
    expect_status("badcs", n0, 0, 5'b00001);

    // Zero length, then checksum fail and pass on a two-byte frame
    n0 = cap_n;
    send_seq('{8'h00, 8'hA5, 8'h00});
    expect_status("len0", n0, 0, 5'b01000);
    n0 = cap_n;
    send_seq('{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h11});
    expect_status("cs11", n0, 0, 5'b00001);
    n0 = cap_n;
    send_seq('{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13});
    expect_status("cs13", n0, 1, 5'b00000);

    // Overflow with the consumer stalled, flag cleared for the next frame
    bus.m_ready = 0;
    n0 = cap_n;
    send_seq('{8'hA5, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h01});
    expect_status("ovf", n0, 0, 5'b10000);
    bus.m_ready = 1;
    n0 = cap_n;
    send_seq('{8'hA5, 8'h01, 8'h5C, 8'h5D});
    expect_status("after_ovf", n0, 1, 5'b00000);

    // Timeout and break aborts
    n0 = cap_n;
    send_seq('{8'hA5, 8'h05, 8'h11});
    repeat (TMO + 2) tick();
    expect_status("tmo", n0, 0, 5'b00010);
    n0 = cap_n;
    send_seq('{8'hA5, 8'h05});
    put_break(); tick(); tick();
    expect_status("brk", n0, 0, 5'b00100);

    // Reset mid-payload with data buffered
    bus.m_ready = 0;
    send_seq('{8'hA5, 8'h05, 8'h11, 8'h22});
    n0 = cap_n;
    rst = 1; tick(); rst = 0;
    check_eq("rst_mid_m_valid", bus.m_valid, 0);
    tick(); tick();
    check_eq("rst_mid_no_done", cap_n - n0, 0);

    // Enable drop mid-frame: silent return to HUNT, FIFO still drains
    send_seq('{8'hA5, 8'h03, 8'h11});
    n0 = cap_n;
    enable = 0; #1;
    check_eq("en_drop_rx_en", uart_rx_en, 0);
    bus.m_ready = 1;
    put_byte(8'h22); tick(); tick();
    check_eq("en_drop_no_done", cap_n - n0, 0);
    check_eq("en_drop_drained", bus.m_valid, 0);
    enable = 1;
    send_seq('{8'h33, 8'h03});
    check_eq("en_drop_hunt", cap_n - n0, 0);

    // Randomized frames against the model
    rdy_rand = 1;
    for (int f = 0; f < 80; f++) begin
      int kind, len, cut;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        put_byte(8'($urandom));
        repeat (rgap()) tick();
      end
      len = (kind == 0) ? MAXL : $urandom_range(1, 8);
      if (kind == 1) len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAXL + 1, 255);
      s.delete();
      s.push_back(SOF);
      s.push_back(8'(len));
      x = 8'(len);
      if (kind != 1) begin
        for (int i = 0; i < len; i++) begin
          s.push_back(8'($urandom));
          x ^= s[s.size() - 1];
        end
        s.push_back((kind == 2) ? ~x : x);
      end
      cut = (kind == 3 || kind == 4) ? $urandom_range(1, s.size() - 1) : -1;
      foreach (s[i]) begin
        if (i == cut) begin
          if (kind == 3) put_break();
          else begin
            enable = 0;
            put_byte(SOF);
            repeat ($urandom_range(0, 2)) tick();
            enable = 1;
          end
          break;
        end
        put_byte(s[i]);
        repeat (rgap()) tick();
      end
    end
    rdy_rand = 0; bus.m_ready = 1;
    repeat (TMO + DEPTH + 4) tick();
    check_eq("final_empty", bus.m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
